// File: rtl/spi_segment_rx_pkg.sv
// Shared command codes, FSM encodings, pin/edge bundles and the hex-to-segment
// decoder for the SPI segment receiver.
package spi_segment_rx_pkg;

    localparam logic [7:0] CMD_SEG_RAW = 8'h01;
    localparam logic [7:0] CMD_SEG_HEX = 8'h02;
    localparam logic [7:0] CMD_BLINK   = 8'h03;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_CMD       = 3'd2,
        ST_DATA      = 3'd3,
        ST_DONE      = 3'd4,
        ST_OVERRUN   = 3'd5
    } state_e;

    typedef struct packed {
        logic sclk;
        logic mosi;
        logic cs_n;
    } spi_pins_t;

    typedef struct packed {
        logic sclk_rise;
        logic sclk_fall;
        logic cs_rise;
        logic cs_fall;
    } spi_edges_t;

    // a..g in bits 0..6, 1 = lit
    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0:    hex2seg = 7'h3F;
            4'h1:    hex2seg = 7'h06;
            4'h2:    hex2seg = 7'h5B;
            4'h3:    hex2seg = 7'h4F;
            4'h4:    hex2seg = 7'h66;
            4'h5:    hex2seg = 7'h6D;
            4'h6:    hex2seg = 7'h7D;
            4'h7:    hex2seg = 7'h07;
            4'h8:    hex2seg = 7'h7F;
            4'h9:    hex2seg = 7'h6F;
            4'hA:    hex2seg = 7'h77;
            4'hB:    hex2seg = 7'h7C;
            4'hC:    hex2seg = 7'h39;
            4'hD:    hex2seg = 7'h5E;
            4'hE:    hex2seg = 7'h79;
            default: hex2seg = 7'h71;
        endcase
    endfunction

    function automatic logic cmd_known(input logic [7:0] cmd);
        cmd_known = (cmd == CMD_SEG_RAW) || (cmd == CMD_SEG_HEX) || (cmd == CMD_BLINK);
    endfunction

endpackage

// File: rtl/spi_seg_sync.sv
// Pin synchroniser for the SPI inputs; edge strobes come from the last two
// synced samples so they are one clk wide and aligned with the synced data.
module spi_seg_sync
    import spi_segment_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  spi_pins_t  pins,
    output logic       mosi_s,
    output logic       cs_n_s,
    output spi_edges_t edges
);

    localparam spi_pins_t PINS_IDLE = '{sclk: 1'b0, mosi: 1'b0, cs_n: 1'b1};

    spi_pins_t [SYNC_STAGES-1:0] chain;
    spi_pins_t                   synced;
    logic                        prev_sclk;
    logic                        prev_cs_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain     <= {SYNC_STAGES{PINS_IDLE}};
            prev_sclk <= 1'b0;
            prev_cs_n <= 1'b1;
        end else begin
            chain     <= {chain[SYNC_STAGES-2:0], pins};
            prev_sclk <= synced.sclk;
            prev_cs_n <= synced.cs_n;
        end
    end

    assign synced          = chain[SYNC_STAGES-1];
    assign mosi_s          = synced.mosi;
    assign cs_n_s          = synced.cs_n;
    assign edges.sclk_rise =  synced.sclk & ~prev_sclk;
    assign edges.sclk_fall = ~synced.sclk &  prev_sclk;
    assign edges.cs_rise   =  synced.cs_n & ~prev_cs_n;
    assign edges.cs_fall   = ~synced.cs_n &  prev_cs_n;

endmodule

// File: rtl/spi_segment_rx.sv
// SPI mode-0 slave taking (cmd, data) frames and holding the 7-segment pattern,
// with optional blink and pattern readback on MISO during the command byte.
module spi_segment_rx
    import spi_segment_rx_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [23:0] MAX_COUNT   = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    output logic [7:0] seg_out,
    output logic       rx_valid,
    output logic       frame_err
);

    spi_pins_t  pins;
    spi_edges_t edges;
    logic       mosi_s;
    logic       cs_n_s;

    assign pins = '{sclk: spi_sclk, mosi: spi_mosi, cs_n: spi_cs_n};

    spi_seg_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pins   (pins),
        .mosi_s (mosi_s),
        .cs_n_s (cs_n_s),
        .edges  (edges)
    );

    // Synced pins only reflect the real pins once the reset values have flushed out
    logic [SYNC_STAGES:0] vld_pipe;
    logic                 sync_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
    end

    assign sync_ok = vld_pipe[SYNC_STAGES];

    state_e      state;
    logic [4:0]  bit_cnt;
    logic [15:0] shreg;
    logic [7:0]  miso_sr;
    logic [7:0]  pattern;
    logic        blink_en;
    logic        phase;
    logic [23:0] blink_cnt;

    logic [7:0]  cmd;
    logic [7:0]  data;
    logic        commit;
    logic        reject;

    assign cmd  = shreg[15:8];
    assign data = shreg[7:0];

    always_comb begin
        commit = 1'b0;
        reject = 1'b0;
        if (edges.cs_rise) begin
            unique case (state)
                ST_DONE: begin
                    commit =  cmd_known(cmd);
                    reject = ~cmd_known(cmd);
                end
                ST_CMD, ST_DATA, ST_OVERRUN: reject = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_WAIT_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            miso_sr   <= '0;
            spi_miso  <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= commit;
            frame_err <= reject;
            if (edges.cs_rise) begin
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                spi_miso <= 1'b0;
            end else begin
                unique case (state)
                    ST_WAIT_IDLE: if (sync_ok && cs_n_s) state <= ST_IDLE;
                    ST_IDLE: if (edges.cs_fall) begin
                        state    <= ST_CMD;
                        bit_cnt  <= '0;
                        miso_sr  <= {pattern[6:0], 1'b0};
                        spi_miso <= pattern[7];
                    end
                    ST_CMD: begin
                        if (edges.sclk_rise) begin
                            shreg   <= {shreg[14:0], mosi_s};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                state    <= ST_DATA;
                                spi_miso <= 1'b0;
                            end
                        end else if (edges.sclk_fall) begin
                            spi_miso <= miso_sr[7];
                            miso_sr  <= {miso_sr[6:0], 1'b0};
                        end
                    end
                    ST_DATA: if (edges.sclk_rise) begin
                        shreg   <= {shreg[14:0], mosi_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15) state <= ST_DONE;
                    end
                    ST_DONE: if (edges.sclk_rise) state <= ST_OVERRUN;
                    ST_OVERRUN: ;
                    default: state <= ST_WAIT_IDLE;
                endcase
            end
        end
    end

    // seg_out is registered from next-state values so it moves in the commit cycle
    logic [7:0]  pattern_nxt;
    logic        blink_en_nxt;
    logic        phase_nxt;
    logic [23:0] blink_cnt_nxt;

    always_comb begin
        pattern_nxt   = pattern;
        blink_en_nxt  = blink_en;
        phase_nxt     = phase;
        blink_cnt_nxt = blink_cnt;
        if (blink_en) begin
            if (blink_cnt == MAX_COUNT - 24'd1) begin
                blink_cnt_nxt = '0;
                phase_nxt     = ~phase;
            end else begin
                blink_cnt_nxt = blink_cnt + 24'd1;
            end
        end
        if (commit) begin
            case (cmd)
                CMD_SEG_RAW: pattern_nxt = data;
                CMD_SEG_HEX: pattern_nxt = {data[7], hex2seg(data[3:0])};
                CMD_BLINK: begin
                    blink_en_nxt  = data[0];
                    blink_cnt_nxt = '0;
                    phase_nxt     = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern   <= '0;
            blink_en  <= 1'b0;
            phase     <= 1'b0;
            blink_cnt <= '0;
            seg_out   <= '0;
        end else begin
            pattern   <= pattern_nxt;
            blink_en  <= blink_en_nxt;
            phase     <= phase_nxt;
            blink_cnt <= blink_cnt_nxt;
            seg_out   <= (blink_en_nxt && phase_nxt) ? 8'h00 : pattern_nxt;
        end
    end

endmodule

// File: tb/tb_spi_segment_rx.sv
// Directed bench for spi_segment_rx: table of frames with expected pattern,
// pulses and readback, then hand sequences for reset, blink and write-while-blink.
module tb_spi_segment_rx;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_miso;
    logic [7:0] seg_out;
    logic       rx_valid;
    logic       frame_err;

    spi_segment_rx #(.SYNC_STAGES(SYNC), .MAX_COUNT(24'd4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .spi_miso  (spi_miso),
        .seg_out   (seg_out),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;

    always @(posedge clk) begin
        if (rx_valid) n_valid++;
        if (frame_err) n_err++;
        if (rx_valid && frame_err) n_both++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // sclk = clk/8; MOSI changes with sclk low, MISO captured just before each rise
    task automatic spi_bits(input logic [31:0] bits, input int n, output logic [15:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = bits[31-i];
            clk_wait(4);
            if (i < 16) cap[15-i] = spi_miso;
            spi_sclk = 1'b1;
            clk_wait(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [31:0] bits, input int n, output logic [15:0] cap);
        @(negedge clk);
        spi_cs_n = 1'b0;
        clk_wait(4);
        spi_bits(bits, n, cap);
        clk_wait(4);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        int         nbits;
        logic [7:0] exp_seg;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_rb;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [15:0] cap;
        logic [7:0]  s[32];
        int          v0, e0, k, lit, bad;

        vecs[0] = '{8'h01, 8'hA5, 16, 8'hA5, 1, 0, 8'h00};
        vecs[1] = '{8'h02, 8'h8B, 16, 8'hFC, 1, 0, 8'hA5};
        vecs[2] = '{8'h02, 8'h00, 16, 8'h3F, 1, 0, 8'hFC};
        vecs[3] = '{8'h01, 8'hA5, 12, 8'h3F, 0, 1, 8'h3F};
        vecs[4] = '{8'h01, 8'hA5, 17, 8'h3F, 0, 1, 8'h3F};
        vecs[5] = '{8'h7E, 8'h55, 16, 8'h3F, 0, 1, 8'h3F};
        vecs[6] = '{8'h02, 8'h0F, 16, 8'h71, 1, 0, 8'h3F};
        vecs[7] = '{8'h01, 8'hA5, 16, 8'hA5, 1, 0, 8'h71};
        vecs[8] = '{8'h00, 8'hFF, 16, 8'hA5, 0, 1, 8'hA5};

        clk_wait(3);
        check("reset_seg", int'(seg_out), 0);
        check("reset_miso", int'(spi_miso), 0);
        check("reset_valid", int'(rx_valid), 0);
        check("reset_err", int'(frame_err), 0);
        rst_n = 1'b1;
        clk_wait(6);

        foreach (vecs[i]) begin
            v0 = n_valid;
            e0 = n_err;
            spi_frame({vecs[i].cmd, vecs[i].data, 1'b1, 15'h0}, vecs[i].nbits, cap);
            clk_wait(SYNC + 2);
            check($sformatf("v%0d_seg", i), int'(seg_out), int'(vecs[i].exp_seg));
            clk_wait(6);
            check($sformatf("v%0d_valid", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("v%0d_err", i), n_err - e0, vecs[i].exp_err);
            check($sformatf("v%0d_miso_cmd", i), int'(cap[15:8]), int'(vecs[i].exp_rb));
            check($sformatf("v%0d_miso_data", i), int'(cap[7:0]), 0);
        end

        // Reset mid-frame, release with cs_n still low: rest of frame must be ignored
        @(negedge clk);
        spi_cs_n = 1'b0;
        clk_wait(4);
        spi_bits({8'h01, 8'h3C, 16'h0}, 5, cap);
        rst_n = 1'b0;
        clk_wait(2);
        check("midrst_seg", int'(seg_out), 0);
        check("midrst_miso", int'(spi_miso), 0);
        check("midrst_valid", int'(rx_valid), 0);
        check("midrst_err", int'(frame_err), 0);
        rst_n = 1'b1;
        v0 = n_valid;
        e0 = n_err;
        clk_wait(4);
        spi_bits({8'h01, 8'h3C, 16'h0}, 16, cap);
        clk_wait(4);
        spi_cs_n = 1'b1;
        clk_wait(10);
        check("midrst_ignored_valid", n_valid - v0, 0);
        check("midrst_ignored_err", n_err - e0, 0);
        check("midrst_ignored_seg", int'(seg_out), 0);

        spi_frame({8'h01, 8'h3C, 16'h0}, 16, cap);
        clk_wait(SYNC + 2);
        check("post_rst_seg", int'(seg_out), 8'h3C);
        check("post_rst_valid", n_valid - v0, 1);

        // Blink on: runs of 4 lit / 4 dark
        spi_frame({8'h03, 8'h01, 16'h0}, 16, cap);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            s[i] = seg_out;
        end
        k = -1;
        for (int i = 1; i < 13; i++)
            if (k < 0 && s[i] == 8'h00 && s[i-1] == 8'h3C) k = i;
        check("blink_first_dark_found", int'(k >= 0), 1);
        if (k >= 0)
            for (int i = 0; i < 16; i++)
                check($sformatf("blink_s%0d", i), int'(s[k+i]),
                      ((i / 4) % 2 == 0) ? 0 : 8'h3C);

        // Pattern write while blinking: only 0x00 / 0x81 seen, half the time lit
        v0 = n_valid;
        spi_frame({8'h01, 8'h81, 16'h0}, 16, cap);
        clk_wait(SYNC + 2);
        lit = 0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (seg_out == 8'h81) lit++;
            else if (seg_out != 8'h00) bad++;
        end
        check("blinkwr_bad_values", bad, 0);
        check("blinkwr_lit_count", lit, 8);
        check("blinkwr_valid", n_valid - v0, 1);

        // Blink off: steady lit
        spi_frame({8'h03, 8'h00, 16'h0}, 16, cap);
        clk_wait(SYNC + 2);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("blinkoff_s%0d", i), int'(seg_out), 8'h81);
        end

        check("valid_err_overlap", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
